// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   HDR_BYTES      : bytes in the word-count header
//   BYTES_PER_WORD : stream bytes packed into one instruction word
//   CSUM_W         : width of the XOR checksum
//   CNT_W, IDX_W   : derived widths of the word counter and byte index
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;

    localparam int CNT_W = 8 * HDR_BYTES;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects stream bytes into a 32-bit instruction word, first byte in the
// most significant position (big-endian).
//   CLK       : clock
//   RST       : asynchronous active-low reset
//   clear     : discard partial word, zero index and word
//   shift_en  : shift din into the word
//   din       : stream byte
//   word      : packed word (valid once word_full is set)
//   byte_idx  : number of bytes already in the current word
//   word_full : the last shift completed a word
// ---------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [7:0]       din,
    output logic [31:0]      word,
    output logic [IDX_W-1:0] byte_idx,
    output logic             word_full
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset branch is listed in the sensitivity list so it acts without a clock.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            word      <= '0;
            byte_idx  <= '0;
            word_full <= 1'b0;
        end else if (clear) begin
            word      <= '0;
            byte_idx  <= '0;
            word_full <= 1'b0;
        end else if (shift_en) begin
            // Shifting left leaves the first byte of the word in [31:24].
            word      <= {word[23:0], din};
            byte_idx  <= byte_idx + 1'b1;
            word_full <= (byte_idx == LAST_IDX);
        end
    end

endmodule

// File: rtl/ins_mem_loader.sv
// ---------------------------------------------------------------------------
// ins_mem_loader
// Serial boot loader for the multi-cycle CPU's instruction memory. Accepts
// a 16-bit word-count header, 4 bytes per instruction and one XOR checksum
// byte over a valid/ready byte stream, and writes each packed word to
// consecutive word-aligned addresses starting at BASE_ADDR.
//   CLK, RST    : clock, asynchronous active-low reset
//   start       : begin a load (honoured in IDLE and DONE only)
//   byte_valid  : byte_data carries a byte
//   byte_data   : stream byte
//   byte_ready  : loader takes a byte this cycle
//   mem_we      : one-cycle instruction-memory write strobe
//   mem_addr    : byte address of the write
//   mem_wdata   : instruction word being written
//   busy        : load in progress
//   done        : load finished, held until the next start
//   err         : header overflow or checksum mismatch (valid with done)
//   word_count  : words written in the current load
// ---------------------------------------------------------------------------
module ins_mem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BYTES_PER_WORD - 1);

    state_t            state;
    logic [7:0]        count_hi;
    logic [CNT_W-1:0]  count;
    logic [CSUM_W-1:0] csum;

    logic              accept;
    logic              start_ok;
    logic [CNT_W-1:0]  hdr_count;
    logic [CNT_W-1:0]  wc_inc;

    logic              pk_clear;
    logic              pk_shift;
    logic [31:0]       pk_word;
    logic [IDX_W-1:0]  pk_idx;
    logic              pk_full;

    assign accept    = byte_valid && byte_ready;
    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign hdr_count = {count_hi, byte_data};
    assign wc_inc    = word_count + 1'b1;

    // The packer restarts on every new load and after every written word,
    // so a stale partial word can never leak into the next one.
    assign pk_clear  = start_ok || (state == S_WRITE);
    assign pk_shift  = (state == S_DATA) && accept;

    byte_packer u_packer (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .din       (byte_data),
        .word      (pk_word),
        .byte_idx  (pk_idx),
        .word_full (pk_full)
    );

    // The packer register is stable through the WRITE cycle and is cleared
    // on reset, so it can drive the write data directly.
    assign mem_wdata = pk_word;

    // byte_ready and busy are registered: each transition writes the value
    // that belongs to the destination state, so they track state exactly.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= BASE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            count_hi   <= '0;
            count      <= '0;
            csum       <= '0;
        end else begin
            mem_we <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_HDR0;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        csum       <= '0;
                    end
                end

                S_HDR0: begin
                    if (accept) begin
                        count_hi <= byte_data;
                        state    <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (accept) begin
                        count <= hdr_count;
                        if (hdr_count > DEPTH_CNT) begin
                            state      <= S_DONE;
                            err        <= 1'b1;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else if (hdr_count == '0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (pk_idx == LAST_IDX) begin
                            // Address is captured with the strobe so all
                            // three write signals change on the same edge.
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                            mem_addr   <= BASE + ADDR_W'(word_count) * WORD_BYTES;
                        end
                    end
                end

                S_WRITE: begin
                    if (pk_full) begin
                        word_count <= wc_inc;
                    end
                    byte_ready <= 1'b1;
                    if (wc_inc == count) begin
                        state <= S_CHK;
                    end else begin
                        state <= S_DATA;
                    end
                end

                S_CHK: begin
                    if (accept) begin
                        if (byte_data != csum) begin
                            err <= 1'b1;
                        end
                        state      <= S_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
